// File: rtl/down_counter_reload_if.sv
// Control/status bundle for the reloadable down counter.
// The master drives the load/enable controls; the slave is the counter.
interface down_counter_reload_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             zero;
  logic             busy;

  modport master (
    output en,
    output load,
    output load_val,
    output auto_reload,
    input  out,
    input  tc,
    input  zero,
    input  busy
  );

  modport slave (
    input  en,
    input  load,
    input  load_val,
    input  auto_reload,
    output out,
    output tc,
    output zero,
    output busy
  );

endinterface : down_counter_reload_if

// File: rtl/down_counter_reload.sv
// Loadable synchronous down counter / interval timer.
// A load captures a start value, which is also kept as the reload value.
// The count then decrements once per enabled cycle in RUN and pulses tc on
// the 1->0 step. Afterwards it either parks in DONE or reloads the saved
// value on the next enabled cycle, so with en held high and a load of N,
// tc repeats every N+1 cycles.
module down_counter_reload #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  down_counter_reload_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_ZERO = '0;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;

  // Next-state and next-datapath decode; load outranks the decrement.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (io_bus.load) begin
      // A load restarts from any state; a zero start value has nothing to
      // count, so it parks in DONE without a terminal-count pulse.
      w_reload_nxt = io_bus.load_val;
      w_out_nxt    = io_bus.load_val;
      w_state_nxt  = (io_bus.load_val != W_ZERO) ? ST_RUN : ST_DONE;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (io_bus.en) begin
            if (r_out > W_ONE) begin
              w_out_nxt = r_out - W_ONE;
            end else if (r_out == W_ONE) begin
              // tc is registered on the same edge that lands on zero, so it
              // is high during the first cycle out reads 0.
              w_out_nxt   = W_ZERO;
              w_tc_nxt    = 1'b1;
              w_state_nxt = io_bus.auto_reload ? ST_RUN : ST_DONE;
            end else begin
              // Only reachable when auto-reloading: the reload step takes the
              // place of a wrap to all-ones.
              w_out_nxt = r_reload;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // Holding: en is ignored until the next load.
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state  <= ST_IDLE;
      r_out    <= W_ZERO;
      r_reload <= W_ZERO;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
    end
  end

  assign io_bus.out  = r_out;
  assign io_bus.tc   = r_tc;
  assign io_bus.busy = r_busy;
  assign io_bus.zero = (r_out == W_ZERO);

  // Structural invariants: tc only ever accompanies a zero count, the count
  // never exceeds the last loaded value, and busy mirrors the RUN state.
  a_tc_at_zero : assert property (@(posedge clk) r_tc |-> (r_out == W_ZERO))
    else $error("tc asserted with nonzero count");
  a_out_le_reload : assert property (@(posedge clk) !$isunknown(r_out) |-> (r_out <= r_reload))
    else $error("count exceeds reload value");
  a_busy_run : assert property (@(posedge clk) !$isunknown(r_state) |-> (r_busy == (r_state == ST_RUN)))
    else $error("busy disagrees with state");

endmodule : down_counter_reload

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload. Stimulus pushes the expected
// registered outputs for the following cycle into a scoreboard queue; an
// independent monitor pops and compares on the falling edge.
module tb_down_counter_reload;

  localparam int WIDTH = 4;

  typedef struct packed {
    int unsigned      cyc;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cycle;
  int          n_checks;
  int          n_pass;
  exp_t        sb_q[$];

  down_counter_reload_if #(.WIDTH(WIDTH)) bus ();

  down_counter_reload #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cycle, act, req);
  endtask

  // Monitor: the counter presents a result every cycle; compare when the
  // head of the scoreboard is due.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
      e = sb_q.pop_front();
      check("cycle_tag", cycle, e.cyc);
      check("out",  bus.out,  e.out);
      check("tc",   bus.tc,   e.tc);
      check("busy", bus.busy, e.busy);
      check("zero", bus.zero, (e.out == '0));
    end
  end

  // Apply one cycle of inputs and record what the outputs must be after it.
  task automatic step(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                      input logic e, input logic ar,
                      input logic [WIDTH-1:0] x_out, input logic x_tc, input logic x_busy);
    exp_t x;
    rst             = r;
    bus.load        = ld;
    bus.load_val    = lv;
    bus.en          = e;
    bus.auto_reload = ar;
    x.cyc  = cycle + 1;
    x.out  = x_out;
    x.tc   = x_tc;
    x.busy = x_busy;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run is a few hundred cycles; this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycle           = 0;
    n_checks        = 0;
    n_pass          = 0;
    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.load        = 1'b0;
    bus.load_val    = '0;
    bus.auto_reload = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then en while idle must not move the count.
    //    rst  ld  lv     en  ar   out    tc  busy
    step(1'b1, 0, 4'd0,  0,  0,  4'd0,  0,  0);
    step(1'b1, 0, 4'd0,  0,  0,  4'd0,  0,  0);
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  0,  0);
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  0,  0);

    // One-shot from 3: 3,2,1,0 with tc alongside the first 0, then parked.
    step(1'b0, 1, 4'd3,  1,  0,  4'd3,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd2,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd1,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  1,  0);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 4'd0, 1, 0, 4'd0, 0, 0);

    // Auto-reload from 2: 2,1,0,2,1,0,2 with tc every third cycle.
    step(1'b0, 1, 4'd2,  1,  1,  4'd2,  0,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd1,  0,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd0,  1,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd2,  0,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd1,  0,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd0,  1,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd2,  0,  1);
    step(1'b0, 0, 4'd0,  0,  1,  4'd2,  0,  1);

    // Enable gap from 5: en 1,0,0,1 gives 4,4,4,3.
    step(1'b0, 1, 4'd5,  0,  0,  4'd5,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd4,  0,  1);
    step(1'b0, 0, 4'd0,  0,  0,  4'd4,  0,  1);
    step(1'b0, 0, 4'd0,  0,  0,  4'd4,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd3,  0,  1);

    // Priority: run down to 1, then load 9 with en high beats the 1->0 step.
    step(1'b0, 0, 4'd0,  1,  0,  4'd2,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd1,  0,  1);
    step(1'b0, 1, 4'd9,  1,  0,  4'd9,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd8,  0,  1);
    // Reset beats a coincident load.
    step(1'b1, 1, 4'd7,  1,  0,  4'd0,  0,  0);
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  0,  0);

    // Reset mid-RUN at count 1: no tc, reset values next cycle.
    step(1'b0, 1, 4'd2,  1,  0,  4'd2,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd1,  0,  1);
    step(1'b1, 0, 4'd0,  1,  0,  4'd0,  0,  0);

    // Maximum load: 15 down to 0 with a single tc at the end.
    step(1'b0, 1, 4'hF,  1,  0,  4'hF,  0,  1);
    for (int v = 14; v >= 0; v--)
      step(1'b0, 0, 4'd0, 1, 0, 4'(v), (v == 0), (v != 0));
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  0,  0);

    // Load of zero goes straight to DONE with no tc.
    step(1'b0, 1, 4'd0,  1,  1,  4'd0,  0,  0);
    step(1'b0, 0, 4'd0,  1,  1,  4'd0,  0,  0);
    step(1'b0, 0, 4'd0,  1,  1,  4'd0,  0,  0);

    // Restart from DONE with a reload value of 1: period of two cycles.
    step(1'b0, 1, 4'd1,  1,  1,  4'd1,  0,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd0,  1,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd1,  0,  1);
    step(1'b0, 0, 4'd0,  1,  1,  4'd0,  1,  1);
    // auto_reload dropped before the 1->0 edge stops the count.
    step(1'b0, 0, 4'd0,  1,  0,  4'd1,  0,  1);
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  1,  0);
    step(1'b0, 0, 4'd0,  1,  0,  4'd0,  0,  0);

    bus.en   = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_down_counter_reload
